// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: single-outstanding load/store sequencer for a word-wide data RAM.
// Sub-word stores use read-modify-write. Load data is right-aligned and sign- or
// zero-extended. Rejected accesses complete with resp_err and leave memory alone.
module dmem_lsu_ctrl #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LDRESP, S_RMW, S_WR, S_ERR
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  state_t            state_q, state_d;
  logic              accept;
  logic              f3_bad, misalign, out_of_range, req_err;
  logic [1:0]        lane_p0;
  logic [2:0]        f3_p0;
  logic              we_p0;
  logic [31:0]       wdata_p0;
  logic [ADDR_W-1:0] waddr_p0;

  // Right-align the addressed lane of a RAM word and extend it per funct3.
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b100:  return {24'd0, b};
      3'b001:  return 32'(h);
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Replace the addressed byte (f3[0]=0) or half (f3[0]=1) of a RAM word.
  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3,
                                              input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    if (!f3[0]) begin
      case (lane)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wd[15:0];
    end else begin
      r[15:0] = wd[15:0];
    end
    return r;
  endfunction

  // Request legality: funct3 encoding, alignment and RAM range.
  always_comb begin
    f3_bad = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: f3_bad = 1'b1;
      3'b100, 3'b101:         f3_bad = req_we;
      default:                f3_bad = 1'b0;
    endcase
    misalign     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    out_of_range = {2'b00, req_addr[31:2]} >= DEPTH_W;
    req_err      = f3_bad || misalign || out_of_range;
  end

  assign accept = req_valid && req_ready;

  // Stage p0: capture the accepted request for the rest of the transaction.
  always_ff @(posedge CLK) begin
    if (accept) begin
      lane_p0  <= req_addr[1:0];
      f3_p0    <= req_funct3;
      we_p0    <= req_we;
      wdata_p0 <= req_wdata;
    end
  end

  // Latched RAM word address; cleared by reset so mem_addr idles at 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      waddr_p0 <= '0;
    end else if (accept) begin
      waddr_p0 <= req_addr[ADDR_W+1:2];
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (!accept)                       state_d = S_IDLE;
        else if (req_err)                  state_d = S_ERR;
        else if (req_we && (req_funct3 == 3'b010)) state_d = S_WR;
        else                               state_d = S_RD;
      end
      S_RD:    state_d = we_p0 ? S_RMW : S_LDRESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs; every strobe and response is suppressed while RST is high.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    mem_addr   = waddr_p0;
    if (!RST) begin
      case (state_q)
        S_IDLE: req_ready = 1'b1;
        S_RD:   mem_re = 1'b1;
        S_LDRESP: begin
          resp_valid = 1'b1;
          resp_rdata = load_extract(mem_rdata, lane_p0, f3_p0);
        end
        S_RMW: begin
          mem_we     = 1'b1;
          mem_wdata  = store_merge(mem_rdata, lane_p0, f3_p0, wdata_p0);
          resp_valid = 1'b1;
        end
        S_WR: begin
          mem_we     = 1'b1;
          mem_wdata  = wdata_p0;
          resp_valid = 1'b1;
        end
        S_ERR: begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Bench for dmem_lsu_ctrl: behavioural RAM plus an array-based reference model.
module tb_dmem_lsu_ctrl;
  localparam int MEM_DEPTH = 1024;
  localparam int ADDR_W    = 10;

  logic              CLK = 1'b0;
  logic              RST;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [31:0]       mem_rdata = '0;
  logic              mem_we;
  logic [31:0]       mem_wdata;

  logic [31:0] ram     [MEM_DEPTH] = '{default: 32'd0};
  logic [31:0] ref_mem [MEM_DEPTH] = '{default: 32'd0};

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  dmem_lsu_ctrl #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 CLK = ~CLK;

  // Word RAM: synchronous write, one-cycle read latency.
  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // One full transaction, checked against the reference model.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic        exp_err, exp_re, exp_we;
    int          exp_lat, lat, n_we, n_re, lane, idx;
    logic [31:0] exp_rd, w, nw, b, h, wr_data;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    exp_err = 1'b0;
    if (f3 == 3 || f3 == 6 || f3 == 7) exp_err = 1'b1;
    if (we && (f3 == 4 || f3 == 5))    exp_err = 1'b1;
    if ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) exp_err = 1'b1;
    if (f3 == 2 && (addr % 4 != 0))    exp_err = 1'b1;
    if (addr / 4 >= MEM_DEPTH)         exp_err = 1'b1;
    idx  = int'((addr / 4) % MEM_DEPTH);
    lane = int'(addr % 4);
    w = ref_mem[idx];
    nw = w;
    exp_rd = 32'd0;
    exp_lat = 2;
    if (exp_err) begin
      exp_lat = 1;
    end else if (!we) begin
      b = (w >> (8 * lane)) & 32'hFF;
      h = (w >> (16 * (lane / 2))) & 32'hFFFF;
      case (f3)
        3'd0:    exp_rd = (b >= 128) ? b + 32'hFFFFFF00 : b;
        3'd4:    exp_rd = b;
        3'd1:    exp_rd = (h >= 32768) ? h + 32'hFFFF0000 : h;
        3'd5:    exp_rd = h;
        default: exp_rd = w;
      endcase
    end else if (f3 == 2) begin
      exp_lat = 1;
      nw = wd;
    end else if (f3 == 0) begin
      nw = (w & ~(32'hFF << (8 * lane))) | ((wd & 32'hFF) << (8 * lane));
    end else begin
      nw = (w & ~(32'hFFFF << (16 * (lane / 2)))) | ((wd & 32'hFFFF) << (16 * (lane / 2)));
    end
    exp_we = !exp_err && we;
    exp_re = !exp_err && !(we && f3 == 2);

    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_req got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    lat = 0; n_we = 0; n_re = 0; wr_data = '0; wr_addr = '0; rd_addr = '0;
    for (int c = 1; c <= 4 && lat == 0; c++) begin
      @(negedge CLK);
      if (mem_we === 1'b1) begin n_we++; wr_data = mem_wdata; wr_addr = mem_addr; end
      if (mem_re === 1'b1) begin n_re++; rd_addr = mem_addr; end
      if (resp_valid === 1'b1) begin
        lat = c; last_rdata = resp_rdata; last_err = resp_err;
      end else begin
        checks++;
        if (resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
          errors++;
          $display("FAIL idle_resp addr=%h got err=%b rdata=%h want 0/0", addr, resp_err, resp_rdata);
        end
      end
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL resp_timeout addr=%h f3=%0d got none want latency %0d", addr, f3, exp_lat);
    end else if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency addr=%h f3=%0d we=%b got %0d want %0d", addr, f3, we, lat, exp_lat);
    end
    checks++;
    if (lat != 0 && (last_err !== exp_err || last_rdata !== exp_rd)) begin
      errors++;
      $display("FAIL resp addr=%h f3=%0d we=%b got err=%b rdata=%h want err=%b rdata=%h",
               addr, f3, we, last_err, last_rdata, exp_err, exp_rd);
    end
    checks++;
    if (n_we != int'(exp_we) || n_re != int'(exp_re)) begin
      errors++;
      $display("FAIL strobes addr=%h f3=%0d we=%b got we=%0d re=%0d want we=%0d re=%0d",
               addr, f3, we, n_we, n_re, exp_we, exp_re);
    end
    if (exp_re) begin
      checks++;
      if (rd_addr !== idx[ADDR_W-1:0]) begin
        errors++;
        $display("FAIL rd_addr got %0d want %0d", rd_addr, idx);
      end
    end
    if (exp_we) begin
      checks++;
      if (wr_addr !== idx[ADDR_W-1:0] || wr_data !== nw) begin
        errors++;
        $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h", wr_addr, wr_data, idx, nw);
      end
      ref_mem[idx] = nw;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if ({mem_we, mem_re, resp_valid, req_ready} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ctrl got we/re/vld/rdy=%b want 0000", {mem_we, mem_re, resp_valid, req_ready});
      end
      checks++;
      if (mem_addr !== '0 || mem_wdata !== '0 || resp_rdata !== '0 || resp_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_data got addr=%h wdata=%h rdata=%h err=%b want 0", mem_addr, mem_wdata, resp_rdata, resp_err);
      end
    end
    RST = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", req_ready);
    end
    @(negedge CLK);
    checks++;
    if (ram[4] !== 32'd0) begin
      errors++;
      $display("FAIL reset_no_write got %h want 00000000", ram[4]);
    end
  endtask

  task automatic test_sw_lw();
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    checks++;
    if (last_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_lw got %h want deadbeef", last_rdata);
    end
  endtask

  task automatic test_subword();
    do_req(1'b1, 3'b000, 32'h11, 32'h00000055);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    checks++;
    if (last_rdata !== 32'hDEAD55EF) begin
      errors++;
      $display("FAIL sb_rmw got %h want dead55ef", last_rdata);
    end
    do_req(1'b1, 3'b001, 32'h12, 32'hABCD1234);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    checks++;
    if (last_rdata !== 32'h123455EF) begin
      errors++;
      $display("FAIL sh_rmw got %h want 123455ef", last_rdata);
    end
  endtask

  task automatic test_extension();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] adrs [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h00000001};
    do_req(1'b1, 3'b010, 32'h10, 32'h80FF7F01);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3s[i], adrs[i], 32'h0);
      checks++;
      if (last_rdata !== exps[i]) begin
        errors++;
        $display("FAIL extension f3=%0d addr=%h got %h want %h", f3s[i], adrs[i], last_rdata, exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic        wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s  [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010};
    logic [31:0] adrs [5] = '{32'h11, 32'h13, 32'h10, 32'h10, 32'h1000};
    for (int i = 0; i < 5; i++) begin
      do_req(wes[i], f3s[i], adrs[i], 32'h12345678);
      checks++;
      if (last_err !== 1'b1) begin
        errors++;
        $display("FAIL error_case %0d got err=%b want 1", i, last_err);
      end
    end
  endtask

  task automatic test_rst_mid_rmw();
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'hAA;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (mem_re !== 1'b1) begin
      errors++;
      $display("FAIL mid_rmw_read got re=%b want 1", mem_re);
    end
    @(posedge CLK);
    #1 RST = 1'b1;
    #2;
    checks++;
    if (mem_we !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rmw_gate got we=%b vld=%b want 0/0", mem_we, resp_valid);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rmw_idle got rdy=%b vld=%b want 1/0", req_ready, resp_valid);
    end
    checks++;
    if (ram[4] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mid_rmw_word got %h want deadbeef", ram[4]);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int i = 0; i < 16; i++) do_req(1'b1, 3'b010, 32'(i * 4), $urandom());
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) addr = $urandom();
      else addr = 32'($urandom_range(0, 63));
      do_req(we, f3, addr, $urandom());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_sw_lw();
    test_subword();
    test_extension();
    test_errors();
    test_rst_mid_rmw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_ctrl.md
# dmem_lsu_ctrl

Load/store sequencer between the RISC-V execute stage and the word-wide data RAM. Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time and drives the RAM word port. Sub-word stores are done as read-modify-write. Load data is extracted right-aligned and sign- or zero-extended. Misaligned, illegal and out-of-range accesses return an error without touching memory.

## Interface
- MEM_DEPTH, 1024: RAM depth in 32-bit words.
- ADDR_W, 10: RAM word-address width, clog2(MEM_DEPTH).
- CLK  in  1  single clock; all state changes on posedge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE and RST low.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_err  out  1  valid with resp_valid; access rejected.
- resp_rdata  out  32  load result; 0 for stores and errors.
- mem_addr  out  ADDR_W  RAM word address, = req_addr[ADDR_W+1:2] latched.
- mem_re  out  1  RAM read strobe; rdata is valid on the next cycle.
- mem_rdata  in  32  RAM read data.
- mem_we  out  1  RAM write strobe; written at the posedge where mem_we is high.
- mem_wdata  out  32  full-word write data.

## Operation
- States: IDLE, RD, LDRESP, RMW, WR, ERR.
- IDLE: req_ready=1. On req_valid, latch addr, funct3, we and wdata, then go to the next state:
  - Error → ERR.
  - Load → RD.
  - SW → WR.
  - SB/SH → RD (read half of the RMW).
- Error conditions, checked in IDLE:
  - Illegal funct3: 011, 110, 111; also 100 or 101 with req_we=1.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - req_addr[31:2] ≥ MEM_DEPTH.
- RD: mem_re=1, mem_addr=latched word address. Next state is LDRESP for a load, RMW for a store.
- LDRESP: resp_valid=1. resp_rdata is built from mem_rdata, with lane = addr[1:0]; byte lane k = bits 8k+7:8k (little-endian). Next state IDLE.
  - B: sign-extend the lane byte.
  - BU: zero-extend the lane byte.
  - H: sign-extend bits 16·addr[1]+15 : 16·addr[1].
  - HU: zero-extend the same half.
  - W: full word.
- RMW: mem_we=1. mem_wdata = mem_rdata with the addressed byte or half replaced by req_wdata[7:0] or req_wdata[15:0]; the other lanes pass through unchanged. resp_valid=1. Next state IDLE.
- WR: mem_we=1, mem_wdata = latched wdata, resp_valid=1. Next state IDLE.
- ERR: resp_valid=1, resp_err=1. mem_re and mem_we stay 0. Next state IDLE.
- mem_we and mem_re are 0 in every state not listed above.

## Timing
- A request is accepted at posedge T when req_valid && req_ready.
- Latencies, in cycles after acceptance (resp_valid high during cycle T+n):
  - SW: n=1.
  - Error: n=1.
  - Loads: n=2.
  - SB/SH: n=2.
- req_ready is low from T+1 until the state returns to IDLE. A new request can be accepted in the cycle after resp_valid.
- resp_rdata and resp_err are held at 0 whenever resp_valid=0.
- Reset values: state IDLE; resp_valid, resp_err, resp_rdata, mem_re, mem_we, mem_addr and mem_wdata all 0. req_ready is 0 while RST=1.
- mem_we and mem_re are gated by !RST. If RST is asserted during the RD, RMW or WR cycle:
  - No write happens at that edge.
  - The operation is dropped with no response.
  - The state is IDLE on the next cycle.
- req_valid high while req_ready=0 is ignored; the requester must hold it.
- RMW is not atomic with respect to other RAM masters. This block is the RAM's only master.

## Test plan
- Reset: hold RST 2 cycles with req_valid=1 → no mem_we/mem_re, resp_valid=0; req_ready=1 on the first cycle after RST falls.
- SW then LW: SW addr 0x10, data 0xDEADBEEF → mem_we at T+1 with mem_addr=4 and resp_valid. Then LW 0x10 → resp_rdata=0xDEADBEEF at T+2.
- Sub-word RMW: word 4 = 0xDEADBEEF.
  - SB addr 0x11, data 0x55 → word = 0xDEAD55EF.
  - SH addr 0x12, data 0x1234 → word = 0x123455EF.
  - Each completes with resp at T+2.
- Extension, word 4 = 0x80FF7F01:
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
  - LH 0x12 → 0xFFFF80FF.
  - LHU 0x10 → 0x00007F01.
  - LB 0x10 → 0x00000001.
- Errors, each → resp_err=1 at T+1 with no mem strobes:
  - LW 0x11.
  - SH 0x13.
  - funct3=011.
  - SBU (we=1, funct3=100).
  - LW addr 0x1000 (word 1024).
- Reset mid-RMW: SB accepted, RST asserted during the RMW cycle → mem_we=0, word unchanged, no resp_valid, IDLE after reset.
